// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if: request, ALU bus and response signals of the ALU issue controller
interface alu_issue_ctrl_if #(parameter int W = 32, parameter int IMMW = 16);
  logic            req_valid;
  logic            req_ready;
  logic [5:0]      opcode;
  logic [5:0]      funct;
  logic [W-1:0]    rs_val;
  logic [W-1:0]    rt_val;
  logic [IMMW-1:0] imm;
  logic [W-1:0]    alu_a;
  logic [W-1:0]    alu_b;
  logic [2:0]      alu_control;
  logic [W-1:0]    alu_out;
  logic            alu_zero;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [W-1:0]    rsp_result;
  logic            rsp_taken;
  logic            rsp_illegal;
  modport slave (
    input  req_valid, opcode, funct, rs_val, rt_val, imm, alu_out, alu_zero, rsp_ready,
    output req_ready, alu_a, alu_b, alu_control, rsp_valid, rsp_result, rsp_taken, rsp_illegal
  );
  modport master (
    output req_valid, opcode, funct, rs_val, rt_val, imm, alu_out, alu_zero, rsp_ready,
    input  req_ready, alu_a, alu_b, alu_control, rsp_valid, rsp_result, rsp_taken, rsp_illegal
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: decodes one instruction per handshake, drives the ALU and returns its result
// ALU_OUT_REG_EN adds a WAIT state so the result is captured one cycle later for a registered ALU
module alu_issue_ctrl #(
  parameter int W    = 32,
  parameter int IMMW = 16
) (
  input logic clk,
  input logic rst_n,
  alu_issue_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic [W-1:0] a_q, a_d, b_q, b_d, result_q, result_d, sext, zext, dec_b;
  logic [2:0] ctl_q, ctl_d, dec_ctl;
  logic slt_q, slt_d, beq_q, beq_d, bne_q, bne_d, ill_q, ill_d;
  logic taken_q, taken_d, illegal_q, illegal_d;
  logic dec_ill, dec_slt, dec_beq, dec_bne, cap;
  always_comb begin
    sext = {{(W-IMMW){bus.imm[IMMW-1]}}, bus.imm};
    zext = {{(W-IMMW){1'b0}}, bus.imm};
    dec_ctl = 3'b000;
    dec_b = bus.rt_val;
    dec_ill = 1'b0;
    dec_slt = 1'b0;
    dec_beq = 1'b0;
    dec_bne = 1'b0;
    if (bus.opcode == 6'b000000)
      case (bus.funct)
        6'b100000: dec_ctl = 3'b010;
        6'b100010: dec_ctl = 3'b011;
        6'b100100: dec_ctl = 3'b000;
        6'b100101: dec_ctl = 3'b001;
        6'b101010: begin dec_ctl = 3'b100; dec_slt = 1'b1; end
        default:   dec_ill = 1'b1;
      endcase
    else
      case (bus.opcode)
        6'b001000:            begin dec_ctl = 3'b010; dec_b = sext; end
        6'b001100:            begin dec_ctl = 3'b000; dec_b = zext; end
        6'b001101:            begin dec_ctl = 3'b001; dec_b = zext; end
        6'b001010:            begin dec_ctl = 3'b100; dec_b = sext; dec_slt = 1'b1; end
        6'b100011, 6'b101011: begin dec_ctl = 3'b010; dec_b = sext; end
        6'b000100:            begin dec_ctl = 3'b110; dec_beq = 1'b1; end
        6'b000101:            begin dec_ctl = 3'b110; dec_bne = 1'b1; end
        default:              dec_ill = 1'b1;
      endcase
    if (dec_ill) begin
      dec_ctl = 3'b000;
      dec_b = '0;
    end
  end
`ifdef ALU_OUT_REG_EN
  assign cap = state_q == WAIT;
`else
  assign cap = state_q == EXEC;
`endif
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    b_d = b_q;
    ctl_d = ctl_q;
    slt_d = slt_q;
    beq_d = beq_q;
    bne_d = bne_q;
    ill_d = ill_q;
    case (state_q)
      IDLE: if (bus.req_valid) begin
        state_d = EXEC;
        a_d = dec_ill ? '0 : bus.rs_val;
        b_d = dec_b;
        ctl_d = dec_ctl;
        slt_d = dec_slt;
        beq_d = dec_beq;
        bne_d = dec_bne;
        ill_d = dec_ill;
      end
      EXEC: state_d =
`ifdef ALU_OUT_REG_EN
        WAIT;
`else
        RESP;
`endif
      WAIT: state_d = RESP;
      RESP: state_d = bus.rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
    result_d = !cap ? result_q : ill_q ? '0 : slt_q ? {{(W-1){1'b0}}, bus.alu_zero} : bus.alu_out;
    taken_d = cap ? (beq_q & bus.alu_zero) | (bne_q & ~bus.alu_zero) : taken_q;
    illegal_d = cap ? ill_q : illegal_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q <= '0;
      b_q <= '0;
      ctl_q <= '0;
      slt_q <= 1'b0;
      beq_q <= 1'b0;
      bne_q <= 1'b0;
      ill_q <= 1'b0;
      result_q <= '0;
      taken_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      b_q <= b_d;
      ctl_q <= ctl_d;
      slt_q <= slt_d;
      beq_q <= beq_d;
      bne_q <= bne_d;
      ill_q <= ill_d;
      result_q <= result_d;
      taken_q <= taken_d;
      illegal_q <= illegal_d;
    end
  end
  assign bus.req_ready = state_q == IDLE;
  assign bus.rsp_valid = state_q == RESP;
  assign bus.alu_a = a_q;
  assign bus.alu_b = b_q;
  assign bus.alu_control = ctl_q;
  assign bus.rsp_result = result_q;
  assign bus.rsp_taken = taken_q;
  assign bus.rsp_illegal = illegal_q;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed and random instructions checked against an instruction-level model
module tb_alu_issue_ctrl;
`ifdef ALU_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int passed = 0;
  int failed = 0;
  int total = 0;
  always #5 clk = ~clk;
  alu_issue_ctrl_if #(.W(32), .IMMW(16)) bus ();
  alu_issue_ctrl #(.W(32), .IMMW(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  // ALU: compare ops report their outcome on zero_flag, arithmetic ops report out==0
  always_comb begin
    case (bus.alu_control)
      3'b000:  bus.alu_out = bus.alu_a & bus.alu_b;
      3'b001:  bus.alu_out = bus.alu_a | bus.alu_b;
      3'b010:  bus.alu_out = bus.alu_a + bus.alu_b;
      3'b011:  bus.alu_out = bus.alu_a - bus.alu_b;
      3'b100:  bus.alu_out = {31'b0, $signed(bus.alu_a) < $signed(bus.alu_b)};
      3'b101:  bus.alu_out = {31'b0, $signed(bus.alu_a) >= $signed(bus.alu_b)};
      3'b110:  bus.alu_out = {31'b0, bus.alu_a == bus.alu_b};
      default: bus.alu_out = '0;
    endcase
    bus.alu_zero = bus.alu_control[2] ? bus.alu_out[0] : bus.alu_out == 32'b0;
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic void model(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] rs,
                                input logic [31:0] rt, input logic [15:0] im, output logic [31:0] res,
                                output logic [31:0] b, output logic [2:0] ctl, output logic tk,
                                output logic il);
    logic [31:0] sx, zx;
    sx = {{16{im[15]}}, im};
    zx = {16'b0, im};
    il = 1'b0;
    tk = 1'b0;
    b = rt;
    ctl = 3'd0;
    res = 32'd0;
    if (op == 6'd0)
      case (fn)
        6'd32:   begin ctl = 3'd2; res = rs + rt; end
        6'd34:   begin ctl = 3'd3; res = rs - rt; end
        6'd36:   begin ctl = 3'd0; res = rs & rt; end
        6'd37:   begin ctl = 3'd1; res = rs | rt; end
        6'd42:   begin ctl = 3'd4; res = {31'b0, $signed(rs) < $signed(rt)}; end
        default: il = 1'b1;
      endcase
    else
      case (op)
        6'd8:         begin ctl = 3'd2; b = sx; res = rs + sx; end
        6'd12:        begin ctl = 3'd0; b = zx; res = rs & zx; end
        6'd13:        begin ctl = 3'd1; b = zx; res = rs | zx; end
        6'd10:        begin ctl = 3'd4; b = sx; res = {31'b0, $signed(rs) < $signed(sx)}; end
        6'd35, 6'd43: begin ctl = 3'd2; b = sx; res = rs + sx; end
        6'd4:         begin ctl = 3'd6; res = {31'b0, rs == rt}; tk = rs == rt; end
        6'd5:         begin ctl = 3'd6; res = {31'b0, rs == rt}; tk = rs != rt; end
        default:      il = 1'b1;
      endcase
    if (il) begin
      b = 32'd0;
      ctl = 3'd0;
      res = 32'd0;
    end
  endfunction
  task automatic do_op(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] rs,
                       input logic [31:0] rt, input logic [15:0] im, input int hold);
    logic [31:0] er, eb;
    logic [2:0] ec;
    logic et, ei;
    int n;
    model(op, fn, rs, rt, im, er, eb, ec, et, ei);
    bus.opcode = op;
    bus.funct = fn;
    bus.rs_val = rs;
    bus.rt_val = rt;
    bus.imm = im;
    bus.req_valid = 1'b1;
    check("req_ready_idle", bus.req_ready, 1);
    @(posedge clk); #1;
    bus.opcode = 6'($urandom);
    bus.funct = 6'($urandom);
    bus.rs_val = $urandom;
    bus.rt_val = $urandom;
    bus.imm = 16'($urandom);
    check("alu_control", bus.alu_control, ec);
    check("alu_a", bus.alu_a, ei ? 32'd0 : rs);
    check("alu_b", bus.alu_b, eb);
    check("exec_rsp_valid", bus.rsp_valid, 0);
    check("exec_req_ready", bus.req_ready, 0);
    n = 0;
    while (bus.rsp_valid !== 1'b1 && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    check("latency", n, LAT);
    check("rsp_result", bus.rsp_result, er);
    check("rsp_taken", bus.rsp_taken, et);
    check("rsp_illegal", bus.rsp_illegal, ei);
    check("resp_req_ready", bus.req_ready, 0);
    repeat (hold) begin
      @(posedge clk); #1;
      check("hold_valid", bus.rsp_valid, 1);
      check("hold_result", bus.rsp_result, er);
      check("hold_taken", bus.rsp_taken, et);
      check("hold_req_ready", bus.req_ready, 0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    check("post_rsp_valid", bus.rsp_valid, 0);
    check("post_req_ready", bus.req_ready, 1);
    check("post_alu_control", bus.alu_control, ec);
    check("post_alu_b", bus.alu_b, eb);
  endtask
  initial begin
    logic [5:0] ops [14];
    logic [5:0] fns [14];
    logic [31:0] rs, rt;
    int k;
    ops = '{6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd8, 6'd12, 6'd13, 6'd10, 6'd35, 6'd43, 6'd4, 6'd5, 6'd0};
    fns = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0};
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b0;
    bus.opcode = '0;
    bus.funct = '0;
    bus.rs_val = '0;
    bus.rt_val = '0;
    bus.imm = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req_ready", bus.req_ready, 1);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_alu_a", bus.alu_a, 0);
    check("rst_alu_b", bus.alu_b, 0);
    check("rst_alu_control", bus.alu_control, 0);
    check("rst_result", bus.rsp_result, 0);
    check("rst_taken", bus.rsp_taken, 0);
    check("rst_illegal", bus.rsp_illegal, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(6'd0, 6'd32, 32'd5, 32'd7, 16'd0, 0);
    do_op(6'd8, 6'd0, 32'd3, 32'd0, 16'hFFFF, 0);
    do_op(6'd13, 6'd0, 32'd0, 32'd0, 16'h8001, 0);
    do_op(6'd0, 6'd42, 32'd2, 32'd9, 16'd0, 0);
    do_op(6'd0, 6'd42, 32'd9, 32'd2, 16'd0, 0);
    do_op(6'd4, 6'd0, 32'd4, 32'd4, 16'd0, 0);
    do_op(6'd5, 6'd0, 32'd4, 32'd4, 16'd0, 0);
    do_op(6'd5, 6'd0, 32'd4, 32'd5, 16'd0, 0);
    do_op(6'd0, 6'd34, 32'd1, 32'd3, 16'd0, 5);
    do_op(6'd63, 6'd0, 32'd12, 32'd34, 16'h1234, 1);
    do_op(6'd0, 6'd3, 32'd12, 32'd34, 16'h1234, 0);
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 13);
      rs = $urandom;
      rt = $urandom_range(0, 1) == 1 ? rs : $urandom;
      do_op(k == 13 ? 6'($urandom_range(48, 63)) : ops[k], k == 13 ? 6'($urandom) : fns[k],
            rs, rt, 16'($urandom), $urandom_range(0, 2));
    end
    bus.opcode = 6'd0;
    bus.funct = 6'd32;
    bus.rs_val = 32'd100;
    bus.rt_val = 32'd1;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("midrst_rsp_valid", bus.rsp_valid, 0);
    check("midrst_req_ready", bus.req_ready, 1);
    check("midrst_alu_a", bus.alu_a, 0);
    check("midrst_alu_b", bus.alu_b, 0);
    check("midrst_alu_control", bus.alu_control, 0);
    check("midrst_result", bus.rsp_result, 0);
    check("midrst_taken", bus.rsp_taken, 0);
    check("midrst_illegal", bus.rsp_illegal, 0);
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("midrst_no_rsp", bus.rsp_valid, 0);
      check("midrst_idle", bus.req_ready, 1);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
